// File: rtl/psum_drain.sv
// Output-side partial-sum drain: de-skews the per-column stream from the array
// and writes each aligned row into the output buffer at base+row.

module psum_drain_lane #(
  parameter int DEPTH = 1,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o
);
  logic [DEPTH-1:0]         vld_pipe_q;
  logic [DEPTH-1:0][DW-1:0] dat_pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= vld_i;
      dat_pipe_q[0] <= dat_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        dat_pipe_q[i] <= dat_pipe_q[i-1];
      end
    end
  end

  assign vld_o = vld_pipe_q[DEPTH-1];
  assign dat_o = dat_pipe_q[DEPTH-1];
endmodule

module psum_drain #(
  parameter int COL = 32,
  parameter int DW  = 16,
  parameter int AW  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [AW-1:0]     base_addr_i,
  input  logic [5:0]        out_rows_i,
  input  logic [COL*DW-1:0] psum_in_i,
  input  logic [COL-1:0]    psum_vld_i,
  output logic              wr_en_o,
  output logic [AW-1:0]     wr_addr_o,
  output logic [COL*DW-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              skew_err_o
);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [5:0]               rc_q, rc_d, rows_q, rows_d;
  logic [AW-1:0]            base_q, base_d, wr_addr_q, wr_addr_d;
  logic                     skew_q, skew_d, wr_en_q, wr_en_d;
  logic [COL*DW-1:0]        wr_data_q, wr_data_d;
  logic [COL-1:0]           av;
  logic [COL-1:0][DW-1:0]   ad;

  // Column j waits COL-1-j cycles so every column's row k lines up with the last column.
  for (genvar j = 0; j < COL-1; j++) begin : g_lane
    psum_drain_lane #(.DEPTH(COL-1-j), .DW(DW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .vld_i (psum_vld_i[j]),
      .dat_i (psum_in_i[j*DW +: DW]),
      .vld_o (av[j]),
      .dat_o (ad[j])
    );
  end
  assign av[COL-1] = psum_vld_i[COL-1];
  assign ad[COL-1] = psum_in_i[(COL-1)*DW +: DW];

  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    rows_d    = rows_q;
    base_d    = base_q;
    skew_d    = skew_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (start_i) begin
        base_d  = base_addr_i;
        rows_d  = (out_rows_i == 6'd0) ? 6'd1 : out_rows_i;
        rc_d    = '0;
        skew_d  = 1'b0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (&av) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + AW'(rc_q);
          wr_data_d = ad;
          rc_d      = rc_q + 6'd1;
          if (rc_q + 6'd1 == rows_q) state_d = DONE;
        end else if (|av) begin
          // Partial row: the array stream lost alignment; flag it and drop the row.
          skew_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rc_q      <= '0;
      rows_q    <= '0;
      base_q    <= '0;
      skew_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      rows_q    <= rows_d;
      base_q    <= base_d;
      skew_q    <= skew_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = (state_q == DRAIN);
  assign done_o     = (state_q == DONE);
  assign skew_err_o = skew_q;
endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: skewed row stimulus, expected writes queued
// at drive time and popped by a write monitor.

module tb_psum_drain;
  localparam int COL = 32, DW = 16, AW = 10;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [5:0]        out_rows = '0;
  logic [COL*DW-1:0] psum_in = '0;
  logic [COL-1:0]    psum_vld = '0;
  logic              wr_en, busy, done, skew_err;
  logic [AW-1:0]     wr_addr;
  logic [COL*DW-1:0] wr_data;

  psum_drain #(.COL(COL), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base_addr),
    .out_rows_i(out_rows), .psum_in_i(psum_in), .psum_vld_i(psum_vld),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .skew_err_o(skew_err)
  );

  typedef struct {
    logic [AW-1:0]     addr;
    logic [COL*DW-1:0] data;
    int                cyc;
    logic              done;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_chk = 0, n_fail = 0, cyc = 0;
  logic          m_act = 1'b0;
  logic [AW-1:0] m_base = '0;
  int            m_rows = 0, m_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [COL*DW-1:0] obs, input logic [COL*DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COL*DW-1:0] row_val(input int tag, input int k);
    logic [COL*DW-1:0] v;
    for (int j = 0; j < COL; j++) v[j*DW +: DW] = DW'((tag << 12) | (k << 8) | j);
    return v;
  endfunction

  always @(negedge clk) if (!rst) begin
    if (wr_en) begin
      chk("write_was_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", wr_addr, mon_e.addr);
        chk("wr_data", wr_data, mon_e.data);
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("done_with_write", done, mon_e.done);
      end
    end else chk("done_without_write", done, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive relative cycle c of a skewed burst; queue the expected write when column 0 issues a row.
  task automatic drive(input int c, input int nrows, input int tag, input int drop_row, input int drop_col);
    exp_t e;
    psum_vld = '0;
    psum_in  = '0;
    for (int j = 0; j < COL; j++) begin
      int k;
      k = c - j;
      if (k >= 0 && k < nrows && !(k == drop_row && j == drop_col)) begin
        psum_vld[j] = 1'b1;
        psum_in[j*DW +: DW] = DW'((tag << 12) | (k << 8) | j);
      end
    end
    if (c < nrows && c != drop_row && m_act) begin
      e.addr = m_base + AW'(m_cnt);
      e.data = row_val(tag, c);
      e.cyc  = cyc + COL;
      e.done = (m_cnt + 1 == m_rows);
      sb.push_back(e);
      m_cnt++;
      if (m_cnt == m_rows) m_act = 1'b0;
    end
  endtask

  task automatic burst(input int nrows, input int tag, input int drop_row, input int drop_col);
    for (int c = 0; c < nrows + COL - 1; c++) begin
      tick();
      drive(c, nrows, tag, drop_row, drop_col);
    end
    tick();
    psum_vld = '0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [5:0] r);
    tick();
    start = 1'b1; base_addr = b; out_rows = r;
    if (!m_act) begin
      m_act = 1'b1; m_base = b; m_rows = (r == 0) ? 1 : int'(r); m_cnt = 0;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
    chk({tag, "_all_writes_seen"}, sb.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_skew_err", skew_err, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Rows before any start, including a partial row: no write, no error.
    burst(3, 1, 1, 7);
    repeat (40) tick();
    chk("prestart_skew_err", skew_err, 0);
    chk("prestart_busy", busy, 0);

    // Nominal 4-row job.
    do_start(10'h040, 6'd4);
    chk("nominal_busy", busy, 1);
    burst(4, 0, -1, -1);
    wait_empty("nominal");
    chk("nominal_busy_after", busy, 0);

    // rows=0 behaves as one row; the trailing row is ignored.
    do_start(10'h155, 6'd0);
    burst(2, 2, -1, -1);
    wait_empty("minimal");
    repeat (40) tick();
    chk("minimal_busy_after", busy, 0);

    // Column 5 missing on row 2: error, row dropped, job waits for a 4th row.
    do_start(10'h200, 6'd4);
    burst(4, 3, 2, 5);
    wait_empty("misalign");
    chk("misalign_skew_err", skew_err, 1);
    chk("misalign_still_busy", busy, 1);
    burst(1, 4, -1, -1);
    wait_empty("misalign_fill");
    chk("misalign_busy_after", busy, 0);
    chk("misalign_err_sticky", skew_err, 1);

    // Address wrap; start also clears the sticky error.
    do_start(10'h3FE, 6'd4);
    chk("start_clears_skew_err", skew_err, 0);
    burst(4, 5, -1, -1);
    wait_empty("wrap");

    // Second start mid-job is ignored.
    do_start(10'h080, 6'd3);
    for (int c = 0; c < 3 + COL - 1; c++) begin
      tick();
      drive(c, 3, 6, -1, -1);
      start = (c == 5);
      if (c == 5) begin base_addr = 10'h300; out_rows = 6'd1; end
    end
    tick();
    psum_vld = '0;
    wait_empty("restart_ignored");
    chk("restart_busy_after", busy, 0);

    // Reset after two of eight rows; in-flight data must not produce writes.
    do_start(10'h100, 6'd8);
    for (int c = 0; c < 8 + COL - 1; c++) begin
      tick();
      drive(c, 8, 7, -1, -1);
      if (c == 33) begin
        @(negedge clk);
        #1;
        chk("rst_mid_pending", sb.size(), 6);
        rst = 1'b1;
        sb.delete();
        m_act = 1'b0;
        #1;
        chk("rst_mid_wr_en", wr_en, 0);
        chk("rst_mid_wr_addr", wr_addr, 0);
        chk("rst_mid_wr_data", wr_data, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
      end
      if (c == 36) rst = 1'b0;
    end
    tick();
    psum_vld = '0;
    repeat (40) tick();
    chk("rst_mid_idle_busy", busy, 0);
    do_start(10'h010, 6'd2);
    burst(2, 8, -1, -1);
    wait_empty("after_reset");
    chk("after_reset_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
